// File: rtl/uart_dbg_loader.sv
// UART (8N1) debug bridge: receives 11-byte write packets from a host and
// issues write requests on the SoC debug register port.
module uart_dbg_loader #(
  parameter int unsigned CLK_DIV     = 868,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rxd_i,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [31:0]       reg_data_o,
  output logic              reg_wr_req_o,
  input  logic              reg_wr_ack_i,
  output logic              busy_o,
  output logic              pkt_err_o,
  output logic [15:0]       wr_count_o
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_SYNC, P_CMD, P_ADDR, P_DATA, P_CSUM, P_WRITE} p_state_t;

  logic            r_sync1, r_sync2, r_rxd_prev;
  rx_state_t       r_rx_state, w_rx_next;
  logic [CW-1:0]   r_bit_cnt, w_bit_cnt;
  logic [2:0]      r_bit_idx, w_bit_idx;
  logic [7:0]      r_shift, w_shift;
  logic            w_byte_valid, w_frame_err;

  p_state_t        r_p_state, w_p_next;
  logic [1:0]      r_bidx, w_bidx;
  logic [7:0]      r_cmd, w_cmd, r_csum, w_csum;
  logic [31:0]     r_addr_sh, w_addr_sh, r_data_sh, w_data_sh;
  logic [TW-1:0]   r_idle, w_idle;
  logic            w_timeout, w_err;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [31:0]     r_data, w_data;
  logic            r_req, w_req, r_err;
  logic [15:0]     r_cnt, w_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rxd_prev <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_sync1    <= uart_rxd_i;
      r_sync2    <= r_sync1;
      r_rxd_prev <= r_sync2;
      r_rx_state <= w_rx_next;
      r_bit_cnt  <= w_bit_cnt;
      r_bit_idx  <= w_bit_idx;
      r_shift    <= w_shift;
    end
  end

  always_comb begin
    w_rx_next    = r_rx_state;
    w_bit_cnt    = r_bit_cnt + 1'b1;
    w_bit_idx    = r_bit_idx;
    w_shift      = r_shift;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_bit_cnt = '0;
        if (r_rxd_prev && !r_sync2) w_rx_next = RX_START;
      end
      RX_START: begin
        if (r_bit_cnt == HALF_M1) begin
          w_bit_cnt = '0;
          w_bit_idx = '0;
          w_rx_next = r_sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_bit_cnt == FULL_M1) begin
          w_bit_cnt = '0;
          w_shift   = {r_sync2, r_shift[7:1]};
          w_bit_idx = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_bit_cnt == FULL_M1) begin
          w_bit_cnt = '0;
          w_rx_next = RX_IDLE;
          if (r_sync2) w_byte_valid = 1'b1;
          else         w_frame_err  = 1'b1;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_state <= P_SYNC;
      r_bidx    <= '0;
      r_cmd     <= '0;
      r_csum    <= '0;
      r_addr_sh <= '0;
      r_data_sh <= '0;
      r_idle    <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_req     <= 1'b0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_p_state <= w_p_next;
      r_bidx    <= w_bidx;
      r_cmd     <= w_cmd;
      r_csum    <= w_csum;
      r_addr_sh <= w_addr_sh;
      r_data_sh <= w_data_sh;
      r_idle    <= w_idle;
      r_addr    <= w_addr;
      r_data    <= w_data;
      r_req     <= w_req;
      r_cnt     <= w_cnt;
      r_err     <= w_err;
    end
  end

  // r_shift holds the completed byte during the byte_valid cycle.
  always_comb begin
    w_p_next  = r_p_state;
    w_bidx    = r_bidx;
    w_cmd     = r_cmd;
    w_csum    = r_csum;
    w_addr_sh = r_addr_sh;
    w_data_sh = r_data_sh;
    w_idle    = '0;
    w_timeout = 1'b0;
    w_addr    = r_addr;
    w_data    = r_data;
    w_req     = r_req;
    w_cnt     = r_cnt;
    w_err     = w_frame_err;
    if (r_p_state != P_SYNC && r_p_state != P_WRITE && !w_byte_valid) begin
      if (r_idle == TO_M1) w_timeout = 1'b1;
      else                 w_idle    = r_idle + 1'b1;
    end
    case (r_p_state)
      P_SYNC: begin
        if (w_byte_valid && r_shift == 8'hA5) w_p_next = P_CMD;
      end
      P_CMD: begin
        if (w_byte_valid) begin
          w_cmd    = r_shift;
          w_csum   = r_shift;
          w_bidx   = '0;
          w_p_next = P_ADDR;
        end
      end
      P_ADDR: begin
        if (w_byte_valid) begin
          w_addr_sh = {r_shift, r_addr_sh[31:8]};
          w_csum    = r_csum ^ r_shift;
          w_bidx    = r_bidx + 2'd1;
          if (r_bidx == 2'd3) w_p_next = P_DATA;
        end
      end
      P_DATA: begin
        if (w_byte_valid) begin
          w_data_sh = {r_shift, r_data_sh[31:8]};
          w_csum    = r_csum ^ r_shift;
          w_bidx    = r_bidx + 2'd1;
          if (r_bidx == 2'd3) w_p_next = P_CSUM;
        end
      end
      P_CSUM: begin
        if (w_byte_valid) begin
          if (r_shift == r_csum && r_cmd == 8'h01) begin
            w_p_next = P_WRITE;
            w_req    = 1'b1;
            w_addr   = r_addr_sh[ADDR_W-1:0];
            w_data   = r_data_sh;
          end else begin
            w_p_next = P_SYNC;
            w_err    = 1'b1;
          end
        end
      end
      P_WRITE: begin
        if (w_byte_valid) w_err = 1'b1;
        if (r_req && reg_wr_ack_i) begin
          w_req    = 1'b0;
          w_cnt    = r_cnt + 16'd1;
          w_p_next = P_SYNC;
        end
      end
      default: w_p_next = P_SYNC;
    endcase
    // A framing error mid-write is reported but leaves the pending write intact.
    if (w_frame_err && r_p_state != P_WRITE) w_p_next = P_SYNC;
    if (w_timeout) begin
      w_err    = 1'b1;
      w_p_next = P_SYNC;
    end
  end

  assign reg_addr_o   = r_addr;
  assign reg_data_o   = r_data;
  assign reg_wr_req_o = r_req;
  assign pkt_err_o    = r_err;
  assign wr_count_o   = r_cnt;
  assign busy_o       = (r_p_state != P_SYNC) | r_req;

endmodule

// File: tb/tb_uart_dbg_loader.sv
// Self-checking bench for uart_dbg_loader: table vectors, random packets
// against a packet-level model, and directed overrun/timeout/reset sequences.
module tb_uart_dbg_loader;

  localparam int CLK_DIV = 16;
  localparam int TO_CYC  = 500;

  logic        clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, ack = 1'b0;
  logic [31:0] addr, data;
  logic        req, busy, perr;
  logic [15:0] wr_count;

  uart_dbg_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd_i(rxd),
    .reg_addr_o(addr), .reg_data_o(data), .reg_wr_req_o(req),
    .reg_wr_ack_i(ack), .busy_o(busy), .pkt_err_o(perr), .wr_count_o(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  cs_xor;
    int          bad_idx;
    int          noise;
    int          dly;
    int          exp_wr;
    int          exp_err;
  } vec_t;

  int vectors = 0, miscompares = 0;
  int errs = 0, cur_len = 0, last_len = 0;
  int ack_delay = 0, ack_cnt = 0, exp_cnt = 0;
  bit ack_auto = 1'b1;
  logic [31:0] cap_addr = '0, cap_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (perr) errs++;
    if (req) cur_len++;
    else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len  = 0;
    end
    if (req && ack) begin
      cap_addr = addr;
      cap_data = data;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (ack_auto) begin
      if (ack) begin
        ack = 1'b0;
        ack_cnt = 0;
      end else if (req) begin
        if (ack_cnt >= ack_delay) ack = 1'b1;
        else ack_cnt++;
      end else ack_cnt = 0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] csum_of(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    logic [7:0] x = c;
    for (int i = 0; i < 4; i++) x ^= a[8*i +: 8] ^ d[8*i +: 8];
    return x;
  endfunction

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(posedge clk); #1;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_ok);
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input vec_t v);
    logic [7:0] nz [3];
    logic [7:0] pk [11];
    nz[0] = 8'h00; nz[1] = 8'hFF; nz[2] = 8'h5A;
    for (int i = 0; i < v.noise; i++) send_byte(nz[i], 1'b1);
    pk[0] = 8'hA5;
    pk[1] = v.cmd;
    for (int i = 0; i < 4; i++) begin
      pk[2+i] = v.addr[8*i +: 8];
      pk[6+i] = v.data[8*i +: 8];
    end
    pk[10] = csum_of(v.cmd, v.addr, v.data) ^ v.cs_xor;
    for (int i = 0; i < 11; i++) send_byte(pk[i], i != v.bad_idx);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int e0, n;
    e0 = errs;
    ack_delay = v.dly;
    send_pkt(v);
    n = 0;
    while ((busy || req) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    exp_cnt += v.exp_wr;
    chk({name, "_busy"}, busy, 0);
    chk({name, "_err"}, errs - e0, v.exp_err);
    chk({name, "_cnt"}, wr_count, 16'(exp_cnt));
    if (v.exp_wr != 0) begin
      chk({name, "_addr"}, cap_addr, v.addr);
      chk({name, "_data"}, cap_data, v.data);
      chk({name, "_reqlen"}, last_len, v.dly + 1);
    end
  endtask

  vec_t tbl [8];
  vec_t rv;

  initial begin
    int e0, n;
    tbl[0] = '{8'h01, 32'h80000000, 32'hDEADBEEF, 8'h00, -1, 0, 3, 1, 0};
    tbl[1] = '{8'h01, 32'h80000000, 32'hDEADBEEF, 8'hA3, -1, 0, 3, 0, 1};
    tbl[2] = '{8'h01, 32'h00001000, 32'h0000BEEF, 8'h00, -1, 3, 1, 1, 0};
    tbl[3] = '{8'h01, 32'h80000000, 32'hDEADBEEF, 8'h00,  6, 0, 2, 0, 1};
    tbl[4] = '{8'h01, 32'h80000000, 32'hDEADBEEF, 8'h00, -1, 0, 2, 1, 0};
    tbl[5] = '{8'h02, 32'h00000010, 32'h00000001, 8'h00, -1, 0, 0, 0, 1};
    tbl[6] = '{8'h01, 32'hFFFFFFFF, 32'h00000000, 8'h00, -1, 0, 0, 1, 0};
    tbl[7] = '{8'h01, 32'h12345678, 32'hA5A5A5A5, 8'h00, -1, 0, 5, 1, 0};

    repeat (4) @(posedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_outs", {addr, data}, 64'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy_err", {busy, perr}, 2'b00);
    chk("init_cnt", wr_count, 0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Timeout: sync + CMD then silence.
    e0 = errs;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    chk("to_busy_before", busy, 1);
    n = 0;
    while (errs == e0 && n < 700) begin
      @(posedge clk); #1;
      n++;
    end
    chk("to_err", errs - e0, 1);
    chk("to_window", (n >= 470 && n <= 530), 1);
    chk("to_busy_after", busy, 0);

    for (int i = 0; i < 12; i++) begin
      rv.cmd     = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'h01;
      rv.addr    = $urandom;
      rv.data    = $urandom;
      rv.cs_xor  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      rv.bad_idx = -1;
      rv.noise   = $urandom_range(0, 3);
      rv.dly     = $urandom_range(0, 4);
      rv.exp_wr  = (rv.cmd == 8'h01 && rv.cs_xor == 8'h00) ? 1 : 0;
      rv.exp_err = 1 - rv.exp_wr;
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // Overrun while the write is held unacknowledged.
    ack_auto = 1'b0;
    ack = 1'b0;
    rv = '{8'h01, 32'hCAFE0000, 32'h01234567, 8'h00, -1, 0, 0, 1, 0};
    e0 = errs;
    send_pkt(rv);
    chk("hold_req", req, 1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    chk("ovr_err", errs - e0, 3);
    chk("ovr_req", req, 1);
    chk("ovr_stable", {addr, data}, {32'hCAFE0000, 32'h01234567});
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    exp_cnt++;
    chk("ovr_ack_req", req, 0);
    chk("ovr_ack_cnt", wr_count, 16'(exp_cnt));
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_ack_cnt", wr_count, 16'(exp_cnt));
    chk("stray_ack_busy", busy, 0);
    chk("hold_addr_after", {addr, data}, {32'hCAFE0000, 32'h01234567});

    // Reset with a write pending: request drops without a clock edge.
    send_pkt(rv);
    chk("rw_req", req, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rw_outs", {req, busy, perr, wr_count}, 19'h0);
    chk("rw_addr_data", {addr, data}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 0;

    // Reset in the middle of a packet.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    rxd = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rp_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rp_outs", {busy, req, wr_count}, 18'h0);
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_auto = 1'b1;
    ack_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    run_vec(tbl[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
